// File: rtl/seq_mult_shift_add.sv
// Radix-2 shift-and-add sequential multiplier with start/ready/done handshake and signed/unsigned mode.
// Define SEQ_MULT_EARLY_TERM_EN to let CALC stop once the remaining multiplier bits are all zero.
module seq_mult_shift_add #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic               calc_exit;
  logic [2*WIDTH-1:0] mag;

  // Magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
  assign a_mag = (is_signed && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_mag = (is_signed && b_in[WIDTH-1]) ? -b_in : b_in;
  assign sum   = {1'b0, acc_hi_q} + (mb_q[0] ? {1'b0, ma_q} : {(WIDTH+1){1'b0}});

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] shamt;
  assign calc_exit = (cnt_q == CNT_W'(WIDTH)) || ((cnt_q != '0) && (mb_q == '0));
  // Partial result sits WIDTH-cnt bits too high; realign before signing.
  assign shamt     = CNT_W'(WIDTH) - cnt_q;
  assign mag       = {acc_hi_q, acc_lo_q} >> shamt;
`else
  assign calc_exit = (cnt_q == CNT_W'(WIDTH));
  assign mag       = {acc_hi_q, acc_lo_q};
`endif

  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ma_d     = a_mag;
          mb_d     = b_mag;
          neg_d    = is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          acc_hi_d = '0;
          acc_lo_d = '0;
          cnt_d    = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (calc_exit) begin
          product_d = neg_q ? -mag : mag;
          state_d   = S_DONE;
        end else begin
          // {carry, acc_hi, acc_lo} shifts right; product bits fill acc_lo from the top.
          acc_hi_d = sum[WIDTH:1];
          acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
          mb_d     = mb_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_CALC) || (state_q == S_DONE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Randomized and directed checks of seq_mult_shift_add against an arithmetic reference model.
module tb_seq_mult_shift_add;
  localparam int W  = 16;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst, start, is_signed;
  logic [W-1:0]  a_in, b_in;
  logic          ready, busy, done;
  logic [PW-1:0] product;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_mult_shift_add #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a_in(a_in), .b_in(b_in), .ready(ready), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint av, bv, p;
    av = s ? longint'($signed(a)) : longint'(a);
    bv = s ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    return p[PW-1:0];
  endfunction

  // Edges from the capture edge to the edge after which done is high.
  function automatic int ref_latency(input logic [W-1:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [W-1:0] m;
    int n;
    m = (s && b[W-1]) ? -b : b;
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  logic [PW-1:0] last_exp;

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit noise);
    int cyc;
    bit seen, hs_bad;
    logic [PW-1:0] exp_p;
    int exp_lat;
    exp_p   = ref_mult(a, b, s);
    exp_lat = ref_latency(b, s);
    cyc = 0;
    while (!ready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("ready_before_start", ready, 1);
    a_in = a; b_in = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = noise;
    if (noise) begin
      a_in = 16'd9; b_in = 16'd9;
    end else begin
      a_in = W'($urandom); b_in = W'($urandom); is_signed = 1'($urandom);
    end
    hs_bad = 0; seen = 0; cyc = 0;
    while (!seen && cyc < 4 * W) begin
      if (ready || !busy) hs_bad = 1;
      @(posedge clk); #1; cyc++;
      if (done) seen = 1;
    end
    if (ready || !busy) hs_bad = 1;
    check("done_seen", seen, 1);
    check("latency", cyc, exp_lat);
    check("product", product, exp_p);
    check("handshake", hs_bad, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("ready_back", ready, 1);
    start = 1'b0;
    last_exp = exp_p;
    $display("[TB] a=0x%04h b=0x%04h s=%0d noise=%0d -> product=0x%08h lat=%0d", a, b, s, noise, product, cyc);
  endtask

  initial begin
    bit any_done;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_mult(16'd3, 16'd5, 1'b0, 1'b0);
    check("const_3x5", product, 32'h0000000F);
    run_mult(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    check("const_max_u", product, 32'hFFFE0001);
    run_mult(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    check("const_m1_m1", product, 32'h00000001);
    run_mult(16'hFFF9, 16'h0006, 1'b1, 1'b0);
    check("const_m7x6", product, 32'hFFFFFFD6);
    repeat (3) @(posedge clk);
    #1;
    check("product_hold", product, 32'hFFFFFFD6);
    run_mult(16'h8000, 16'h8000, 1'b1, 1'b0);
    check("const_min_min", product, 32'h40000000);
    run_mult(16'h8000, 16'hFFFF, 1'b1, 1'b0);
    run_mult(16'd2, 16'd2, 1'b0, 1'b1);
    check("const_hs_2x2", product, 32'd4);
    run_mult(16'h1234, 16'h0000, 1'b0, 1'b0);
    run_mult(16'h1234, 16'h0001, 1'b0, 1'b0);
    run_mult(16'h1234, 16'h8000, 1'b0, 1'b0);

    // Reset in the middle of an operation discards it.
    a_in = 16'd100; b_in = 16'd100; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_product", product, 0);
    any_done = done;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (done) any_done = 1;
    end
    check("midrst_no_done", any_done, 0);
    run_mult(16'd7, 16'd8, 1'b0, 1'b0);
    check("const_7x8", product, 32'd56);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 16'h8000;
        1: ra = 16'hFFFF;
        2: ra = 16'h0000;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rb = 16'h8000;
        1: rb = W'($urandom_range(0, 15));
        2: rb = 16'h0001;
        default: rb = W'($urandom);
      endcase
      run_mult(ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
